// File: rtl/l2_line_adapter_pkg.sv
// ----------------------------------------------------------------------------
// l2_pkg
// Shared definitions for the L2 line-to-burst adapter.
//   L2_LINE_W   : default cache line width in bits
//   L2_BEAT_W   : default memory burst beat width in bits
//   L2_ADDR_W   : default byte address width
//   L2_BEATS    : beats per line at the default widths
//   L2_OFFSET_W : byte-offset bits inside one line at the default widths
//   l2_state_e  : adapter FSM state encoding
// ----------------------------------------------------------------------------
package l2_pkg;

    localparam int L2_LINE_W   = 256;
    localparam int L2_BEAT_W   = 64;
    localparam int L2_ADDR_W   = 32;
    localparam int L2_BEATS    = L2_LINE_W / L2_BEAT_W;
    localparam int L2_OFFSET_W = $clog2(L2_LINE_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } l2_state_e;

endpackage

// File: rtl/l2_line_adapter.sv
// ----------------------------------------------------------------------------
// l2_line_adapter
// Converts one full-line read/write request from the L2 controller into a
// BEATS-long burst on the physical-memory interface, then answers with a
// single-cycle pmem_resp.
//
// Ports
//   clk, rst              : clock (rising edge), async active-high reset
//   pmem_read/pmem_write  : line request level from L2 control (held to resp)
//   pmem_address          : line address from L2 datapath
//   pmem_wdata            : line to write back
//   pmem_rdata            : assembled read line (line buffer)
//   pmem_resp             : one-cycle completion pulse
//   mem_read/mem_write    : burst request to memory
//   mem_address           : line-aligned burst address
//   mem_wdata             : current write beat
//   mem_rdata             : current read beat
//   mem_resp              : one beat transferred per high cycle
// ----------------------------------------------------------------------------
module l2_line_adapter
    import l2_pkg::*;
#(
    parameter int LINE_W = L2_LINE_W,
    parameter int BEAT_W = L2_BEAT_W,
    parameter int ADDR_W = L2_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_W / 8);

    l2_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_line;
    logic              last_beat;
    logic [BEAT_W-1:0] beat_arr [BEATS];

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // ------------------------------------------------------------------
    // Next-state logic. Write has priority over read on accept. The
    // counter is exactly log2(BEATS) bits so it wraps to 0 by itself
    // after the last beat.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        load_line = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pmem_write || pmem_read) begin
                    state_d   = pmem_write ? ST_WRITE : ST_READ;
                    load_line = pmem_write;
                    addr_d    = {pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    cnt_d     = '0;
                end
            end
            ST_READ, ST_WRITE: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Requests are deliberately ignored here; a still-high
                // request is taken as a new one in the following IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffer, one register per beat. A write accept loads the whole
    // line; during a read each accepted beat lands in slot cnt_q.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] beat_q;
            logic              rd_we;

            assign rd_we = (state_q == ST_READ) && mem_resp && (cnt_q == CNT_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    beat_q <= '0;
                end else if (load_line) begin
                    beat_q <= pmem_wdata[gi*BEAT_W +: BEAT_W];
                end else if (rd_we) begin
                    beat_q <= mem_rdata;
                end
            end

            assign beat_arr[gi]                    = beat_q;
            assign pmem_rdata[gi*BEAT_W +: BEAT_W] = beat_q;
        end
    endgenerate

    // Outputs depend only on registered state, counter, address and buffer.
    assign mem_read    = (state_q == ST_READ);
    assign mem_write   = (state_q == ST_WRITE);
    assign pmem_resp   = (state_q == ST_DONE);
    assign mem_address = addr_q;
    assign mem_wdata   = beat_arr[cnt_q];

endmodule

// File: tb/tb_l2_line_adapter.sv
module tb_l2_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    always #5 clk = ~clk;

    l2_line_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    typedef struct {
        logic         is_read;
        logic [31:0]  addr;
        logic [255:0] rdata;
        int           lat;
        int           start_gap;
    } exp_t;

    exp_t        exp_resp [$];
    logic [63:0] exp_wbeat [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_seen = 0;
    bit fin_req = 0;
    bit fin_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [63:0] rd_beats [4];
    int gap = 0;
    int bi = 0;
    int wait_cnt = 0;

    always @(negedge clk) begin
        if (rst || !(mem_read || mem_write)) begin
            mem_resp  = 1'b0;
            mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            bi        = 0;
            wait_cnt  = gap;
        end else if (wait_cnt >= gap) begin
            mem_resp  = 1'b1;
            mem_rdata = rd_beats[bi % 4];
            bi        = bi + 1;
            wait_cnt  = 0;
        end else begin
            mem_resp  = 1'b0;
            mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            wait_cnt  = wait_cnt + 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    bit   active = 0;
    bit   has_cur = 0;
    exp_t cur;
    int   acc_cyc = 0;
    int   last_resp_cyc = 0;
    int   active_cycles = 0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            active  = 0;
            has_cur = 0;
            chk("rst_mem_read",    {255'd0, mem_read},   256'd0);
            chk("rst_mem_write",   {255'd0, mem_write},  256'd0);
            chk("rst_pmem_resp",   {255'd0, pmem_resp},  256'd0);
            chk("rst_mem_address", {224'd0, mem_address}, 256'd0);
            chk("rst_mem_wdata",   {192'd0, mem_wdata},  256'd0);
            chk("rst_pmem_rdata",  pmem_rdata,           256'd0);
        end else begin
            if (mem_read && mem_write) begin
                chk("rw_exclusive", {254'd0, mem_read, mem_write}, 256'd2);
            end
            if (!active && (mem_read || mem_write)) begin
                active        = 1;
                active_cycles = 0;
                acc_cyc       = cyc;
                checks++;
                if (exp_resp.size() == 0) begin
                    errors++;
                    has_cur = 0;
                    $display("FAIL burst_start: got unexpected burst want none");
                end else begin
                    cur     = exp_resp[0];
                    has_cur = 1;
                    chk("mem_address", {224'd0, mem_address}, {224'd0, cur.addr});
                    if (cur.start_gap >= 0)
                        chk("restart_gap", 256'(cyc - last_resp_cyc), 256'(cur.start_gap));
                end
            end
            if (active && !pmem_resp && has_cur) begin
                chk("burst_kind", {254'd0, mem_read, mem_write},
                    {254'd0, cur.is_read, ~cur.is_read});
            end
            if (active) begin
                active_cycles++;
                if (active_cycles > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL burst_timeout: got no pmem_resp want one within 200 cycles");
                    active  = 0;
                    has_cur = 0;
                end
            end
            if (mem_write && mem_resp) begin
                if (exp_wbeat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wbeat: got extra beat %0h want none", mem_wdata);
                end else begin
                    chk("mem_wdata", {192'd0, mem_wdata}, {192'd0, exp_wbeat.pop_front()});
                end
            end
            if (pmem_resp) begin
                resp_seen++;
                chk("resp_quiet", {254'd0, mem_read, mem_write}, 256'd0);
                if (exp_resp.size() == 0 || !has_cur) begin
                    checks++;
                    errors++;
                    $display("FAIL pmem_resp: got unexpected pulse want none");
                end else begin
                    void'(exp_resp.pop_front());
                    chk("resp_latency", 256'(cyc + 1 - acc_cyc), 256'(cur.lat));
                    if (cur.is_read)
                        chk("pmem_rdata", pmem_rdata, cur.rdata);
                    else
                        chk("wbeats_left", 256'(exp_wbeat.size()), 256'd0);
                end
                active        = 0;
                has_cur       = 0;
                last_resp_cyc = cyc;
            end
        end
        if (fin_req && !fin_done) begin
            chk("resp_queue_empty", 256'(exp_resp.size()), 256'd0);
            chk("wbeat_queue_empty", 256'(exp_wbeat.size()), 256'd0);
            fin_done = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic is_read, input logic [31:0] addr,
                            input logic [255:0] rdata, input int lat, input int sgap);
        exp_t e;
        e.is_read   = is_read;
        e.addr      = addr;
        e.rdata     = rdata;
        e.lat       = lat;
        e.start_gap = sgap;
        exp_resp.push_back(e);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wdata, input int n_resp);
        int  start;
        bit  done;
        @(negedge clk);
        #2;
        start        = resp_seen;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        done         = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            #2;
            if (resp_seen >= start + n_resp) done = 1;
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        $display("req rd=%0b wr=%0b addr=%08h responses=%0d", rd, wr, addr, resp_seen - start);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        rd_beats     = '{64'h0, 64'h0, 64'h0, 64'h0};
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        // Plain read, back-to-back beats.
        rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        push_exp(1'b1, 32'h1234_5660,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 5, -1);
        do_req(1'b1, 1'b0, 32'h1234_567F, '0, 1);

        // Line write.
        push_exp(1'b0, 32'h0000_8000, '0, 5, -1);
        exp_wbeat.push_back(64'h0123_4567_89AB_CDEF);
        exp_wbeat.push_back(64'hFEDC_BA98_7654_3210);
        exp_wbeat.push_back(64'hDEAD_BEEF_CAFE_F00D);
        exp_wbeat.push_back(64'h0F1E_2D3C_4B5A_6978);
        do_req(1'b0, 1'b1, 32'h0000_801C,
               {64'h0F1E_2D3C_4B5A_6978, 64'hDEAD_BEEF_CAFE_F00D,
                64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 1);

        // Read with two idle cycles between beats.
        gap      = 2;
        rd_beats = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                     64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        push_exp(1'b1, 32'hABCD_EF00,
                 {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 11, -1);
        do_req(1'b1, 1'b0, 32'hABCD_EF1F, '0, 1);
        gap = 0;

        // Read and write together: write wins.
        push_exp(1'b0, 32'h0000_0040, '0, 5, -1);
        exp_wbeat.push_back(64'h5555_5555_5555_5555);
        exp_wbeat.push_back(64'h6666_6666_6666_6666);
        exp_wbeat.push_back(64'h7777_7777_7777_7777);
        exp_wbeat.push_back(64'h8888_8888_8888_8888);
        do_req(1'b1, 1'b1, 32'h0000_004C,
               {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}, 1);

        // Reset after two write beats have been accepted.
        push_exp(1'b0, 32'h0000_1000, '0, 5, -1);
        exp_wbeat.push_back(64'hF0F0_F0F0_F0F0_F0F0);
        exp_wbeat.push_back(64'hF1F1_F1F1_F1F1_F1F1);
        exp_wbeat.push_back(64'hF2F2_F2F2_F2F2_F2F2);
        exp_wbeat.push_back(64'hF3F3_F3F3_F3F3_F3F3);
        @(negedge clk);
        #2;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_1000;
        pmem_wdata   = {64'hF3F3_F3F3_F3F3_F3F3, 64'hF2F2_F2F2_F2F2_F2F2,
                        64'hF1F1_F1F1_F1F1_F1F1, 64'hF0F0_F0F0_F0F0_F0F0};
        repeat (3) @(negedge clk);
        #2;
        rst        = 1'b1;
        pmem_write = 1'b0;
        exp_resp.delete();
        exp_wbeat.delete();
        $display("reset asserted mid write burst");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // A read after the aborted write completes normally.
        rd_beats = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                     64'hC3C3_C3C3_C3C3_C3C3, 64'h3C3C_3C3C_3C3C_3C3C};
        push_exp(1'b1, 32'hFFFF_FFE0,
                 {64'h3C3C_3C3C_3C3C_3C3C, 64'hC3C3_C3C3_C3C3_C3C3,
                  64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5}, 5, -1);
        do_req(1'b1, 1'b0, 32'hFFFF_FFE5, '0, 1);

        // Request held through DONE: second burst two cycles after DONE.
        rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        push_exp(1'b1, 32'h0000_0020,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 5, -1);
        push_exp(1'b1, 32'h0000_0020,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 5, 2);
        do_req(1'b1, 1'b0, 32'h0000_0020, '0, 2);

        repeat (8) @(negedge clk);
        fin_req = 1;
        repeat (2) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_line_adapter.md
# l2_line_adapter

Line-to-burst adapter directly downstream of the L2 cache controller: it accepts one full-line read or write request on the controller's `pmem_*` handshake and converts it into a multi-beat burst on the physical-memory interface. For reads it assembles the incoming beats into a line; for writes it serialises a latched line into beats. It answers the controller with a single-cycle `pmem_resp` once the whole line has transferred.

## Interface
- `LINE_W`, 256, cache line width in bits.
- `BEAT_W`, 64, memory burst beat width in bits; `BEATS = LINE_W/BEAT_W` must be a power of two ≥ 2.
- `ADDR_W`, 32, byte address width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `pmem_read`  in  1  line read request from L2 control; level, held until `pmem_resp`.
- `pmem_write`  in  1  line write request from L2 control; level, held until `pmem_resp`.
- `pmem_address`  in  ADDR_W  line address from L2 datapath.
- `pmem_wdata`  in  LINE_W  line to write back.
- `pmem_rdata`  out  LINE_W  assembled read line.
- `pmem_resp`  out  1  one-cycle completion pulse to L2 control.
- `mem_read`  out  1  burst read request to memory.
- `mem_write`  out  1  burst write request to memory.
- `mem_address`  out  ADDR_W  line-aligned burst address.
- `mem_wdata`  out  BEAT_W  current write beat.
- `mem_rdata`  in  BEAT_W  current read beat.
- `mem_resp`  in  1  beat accepted or beat valid; one beat per high cycle.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if `pmem_write` is high, latch `pmem_wdata` into the line buffer and go to WRITE. Otherwise, if `pmem_read` is high, go to READ. Write wins if both are high.
- On either accept, latch `pmem_address` with the low log2(LINE_W/8) bits forced to zero; drive it on `mem_address`. Clear the beat counter.
- READ: `mem_read`=1. Each cycle with `mem_resp`=1, store `mem_rdata` into buffer bits [BEAT_W*k +: BEAT_W], where k is the counter value, then increment the counter. On the beat with k = BEATS-1, go to DONE.
- WRITE: `mem_write`=1 and `mem_wdata` = buffer beat k (combinational from the counter). Each cycle with `mem_resp`=1, increment the counter. On the last beat, go to DONE.
- DONE: `pmem_resp`=1 for exactly one cycle, then go to IDLE unconditionally. Requests are ignored in DONE; a request still high in the next IDLE cycle is accepted as new.
- `mem_resp` is ignored in IDLE and DONE.
- `pmem_rdata` is driven from the line buffer. It is valid in DONE after a read and holds until the next accept.
- Counter is log2(BEATS) bits and wraps to 0 after the last beat.
- `mem_read` and `mem_write` are never high together.

## Timing
- Reset values: state IDLE, counter 0, buffer 0, address 0. Outputs: `mem_read`=0, `mem_write`=0, `pmem_resp`=0, `mem_address`=0, `mem_wdata`=0, `pmem_rdata`=0.
- Reset asserted mid-burst aborts immediately to IDLE; no `pmem_resp` is issued.
- Request seen at edge N: `mem_read` or `mem_write` is high from cycle N+1.
- With back-to-back `mem_resp`, `pmem_resp` arrives at cycle N+1+BEATS (N+5 by default). Each `mem_resp`-low cycle adds one cycle.
- All outputs are decoded from registered state, counter and buffer; there is no combinational path from `pmem_*` inputs to outputs.

## Structure
- Shared package `l2_pkg`: `LINE_W`/`BEAT_W`/`ADDR_W` defaults, `BEATS` and `OFFSET_W` constants, and the adapter state enum typedef.
- Single module, no sub-module. Buffer, counter and FSM are inline.

## Test plan
- Read: `pmem_read`, addr 0x1234_567F; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back. Required: `mem_address`=0x1234_5660; `pmem_resp` at cycle N+5; `pmem_rdata` = {0x44..,0x33..,0x22..,0x11..}.
- Write: `pmem_wdata`={D3,D2,D1,D0}. Required: `mem_wdata` shows D0, D1, D2, D3 on successive `mem_resp` cycles, then a single `pmem_resp`.
- Stalled read: `mem_resp` gaps of 2 cycles between beats. Required: beats are assembled in order, `mem_read` is held throughout, and `pmem_resp` is delayed by 6 cycles.
- Simultaneous `pmem_read`+`pmem_write`. Required: write burst only, and `mem_read` stays 0.
- `rst` after beat 2 of a write. Required: next cycle is IDLE, all outputs 0, no `pmem_resp`; a subsequent read completes normally.
- Request held high through DONE. Required: one `pmem_resp` pulse, and a second burst starts two cycles after DONE.
